// File: rtl/path_query_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// path_query_sequencer_pkg
// Shared definitions for the path query sequencer:
//   - default widths and table depth (NODE_W, DIR_W, MAX_WP)
//   - settle counter width (covers SETTLE_CYCLES up to 65535)
//   - FSM state encoding (IDLE, SETTLE, PRESENT, DONE)
// ---------------------------------------------------------------------------
package path_query_sequencer_pkg;

  localparam int NODE_W_DEF = 8;
  localparam int DIR_W_DEF  = 64;
  localparam int MAX_WP_DEF = 16;
  localparam int CNT_W      = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/path_query_sequencer_table.sv
// ---------------------------------------------------------------------------
// waypoint_table
// Append-only waypoint store with two combinational read ports.
// Ports:
//   clk_50, rst_n       : clock, asynchronous active-low reset (count only)
//   wr_en, wr_data      : append wr_data at index count (ignored when full)
//   clr                 : empty the table (wins over wr_en)
//   count               : number of stored waypoints
//   rd_addr_a/b         : read addresses, rd_data_a/b : read data
// Table contents are not reset; only the count is.
// ---------------------------------------------------------------------------
module waypoint_table
  import path_query_sequencer_pkg::*;
#(
  parameter int NODE_W = NODE_W_DEF,
  parameter int MAX_WP = MAX_WP_DEF
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [NODE_W-1:0] wr_data,
  input  logic              clr,
  output logic [4:0]        count,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [NODE_W-1:0] rd_data_a,
  output logic [NODE_W-1:0] rd_data_b
);

  localparam int AW = (MAX_WP > 1) ? $clog2(MAX_WP) : 1;
  localparam logic [4:0] DEPTH = 5'(MAX_WP);

  logic [NODE_W-1:0] table_reg [MAX_WP];
  logic [4:0]        count_reg;

  logic do_write;
  assign do_write = wr_en && !clr && (count_reg < DEPTH);

  always_ff @(posedge clk_50) begin
    if (do_write) begin
      table_reg[count_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 5'd0;
    end else if (clr) begin
      count_reg <= 5'd0;
    end else if (do_write) begin
      count_reg <= count_reg + 5'd1;
    end
  end

  // Out-of-range addresses read as zero rather than aliasing into the array.
  assign rd_data_a = (rd_addr_a < DEPTH) ? table_reg[rd_addr_a[AW-1:0]] : '0;
  assign rd_data_b = (rd_addr_b < DEPTH) ? table_reg[rd_addr_b[AW-1:0]] : '0;
  assign count     = count_reg;

endmodule

// File: rtl/path_query_sequencer.sv
// ---------------------------------------------------------------------------
// path_query_sequencer
// Walks a stored list of waypoints, presenting each consecutive pair
// (wp[i], wp[i+1]) to an external path engine, waiting SETTLE_CYCLES for the
// engine to settle, capturing its direction word and handing it to a
// consumer over a valid/ready handshake.
// Ports:
//   clk_50, rst_n                    : clock, asynchronous active-low reset
//   wp_wr, wp_data, wp_clear         : waypoint table load (IDLE only)
//   wp_count                         : number of stored waypoints
//   run, abort                       : start / terminate a sequence
//   busy                             : high whenever not IDLE
//   starting_node, ending_node       : current leg, to the path engine
//   direction_in                     : direction word from the path engine
//   leg_dir, leg_valid, leg_ready    : captured leg output handshake
//   leg_idx                          : index of the current leg
//   seq_done                         : one-cycle pulse at sequence end
//   err_short                        : one-cycle pulse when run is rejected
// ---------------------------------------------------------------------------
module path_query_sequencer
  import path_query_sequencer_pkg::*;
#(
  parameter int NODE_W        = NODE_W_DEF,
  parameter int DIR_W         = DIR_W_DEF,
  parameter int MAX_WP        = MAX_WP_DEF,
  parameter int SETTLE_CYCLES = 20000
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              wp_wr,
  input  logic [NODE_W-1:0] wp_data,
  input  logic              wp_clear,
  output logic [4:0]        wp_count,
  input  logic              run,
  input  logic              abort,
  output logic              busy,
  output logic [NODE_W-1:0] starting_node,
  output logic [NODE_W-1:0] ending_node,
  input  logic [DIR_W-1:0]  direction_in,
  output logic [DIR_W-1:0]  leg_dir,
  output logic              leg_valid,
  input  logic              leg_ready,
  output logic [3:0]        leg_idx,
  output logic              seq_done,
  output logic              err_short
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  counter_reg;
  logic [3:0]        leg_idx_reg;
  logic [NODE_W-1:0] starting_node_reg;
  logic [NODE_W-1:0] ending_node_reg;
  logic [DIR_W-1:0]  leg_dir_reg;
  logic              leg_valid_reg;
  logic              err_short_reg;

  logic              in_idle;
  logic [4:0]        rd_addr_a;
  logic [4:0]        rd_addr_b;
  logic [NODE_W-1:0] rd_data_a;
  logic [NODE_W-1:0] rd_data_b;
  logic              more_legs;

  assign in_idle = (state_reg == ST_IDLE);

  // In IDLE the read ports point at the first leg; otherwise at the next leg.
  assign rd_addr_a = in_idle ? 5'd0 : ({1'b0, leg_idx_reg} + 5'd1);
  assign rd_addr_b = in_idle ? 5'd1 : ({1'b0, leg_idx_reg} + 5'd2);
  assign more_legs = ({1'b0, leg_idx_reg} + 5'd2) < wp_count;

  waypoint_table #(
    .NODE_W (NODE_W),
    .MAX_WP (MAX_WP)
  ) u_table (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .wr_en     (wp_wr && in_idle),
    .wr_data   (wp_data),
    .clr       (wp_clear && in_idle),
    .count     (wp_count),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      counter_reg       <= '0;
      leg_idx_reg       <= 4'd0;
      starting_node_reg <= '0;
      ending_node_reg   <= '0;
      leg_dir_reg       <= '0;
      leg_valid_reg     <= 1'b0;
      err_short_reg     <= 1'b0;
    end else begin
      err_short_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (run) begin
            if (wp_count >= 5'd2) begin
              starting_node_reg <= rd_data_a;
              ending_node_reg   <= rd_data_b;
              leg_idx_reg       <= 4'd0;
              counter_reg       <= '0;
              state_reg         <= ST_SETTLE;
            end else begin
              err_short_reg <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            leg_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end else if (counter_reg == LAST_COUNT) begin
            // Counter started at 0 on the node change, so this edge is
            // exactly SETTLE_CYCLES edges later.
            leg_dir_reg   <= direction_in;
            leg_valid_reg <= 1'b1;
            state_reg     <= ST_PRESENT;
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        ST_PRESENT: begin
          if (abort) begin
            leg_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end else if (leg_valid_reg && leg_ready) begin
            leg_valid_reg <= 1'b0;
            if (more_legs) begin
              leg_idx_reg       <= leg_idx_reg + 4'd1;
              starting_node_reg <= rd_data_a;
              ending_node_reg   <= rd_data_b;
              counter_reg       <= '0;
              state_reg         <= ST_SETTLE;
            end else begin
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = !in_idle;
  assign seq_done      = (state_reg == ST_DONE);
  assign err_short     = err_short_reg;
  assign starting_node = starting_node_reg;
  assign ending_node   = ending_node_reg;
  assign leg_dir       = leg_dir_reg;
  assign leg_valid     = leg_valid_reg;
  assign leg_idx       = leg_idx_reg;

endmodule

// File: doc/path_query_sequencer.md
PATH_QUERY_SEQUENCER -- requirements
Module: path_query_sequencer

Interface
REQ-001 SHALL have parameter NODE_W, default 8, meaning node-index width.
REQ-002 SHALL have parameter DIR_W, default 64, meaning direction-word width.
REQ-003 SHALL have parameter MAX_WP, default 16, meaning waypoint table depth.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 20000, meaning cycles each leg is held before capture (legal range 1..65535).
REQ-005 SHALL have port clk_50, input, 1 bit, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port wp_wr, input, 1 bit, appends wp_data to the waypoint table.
REQ-008 SHALL have port wp_data, input, NODE_W bits, waypoint node index.
REQ-009 SHALL have port wp_clear, input, 1 bit, empties the waypoint table.
REQ-010 SHALL have port wp_count, output, 5 bits, number of stored waypoints.
REQ-011 SHALL have port run, input, 1 bit, requests start of a sequence.
REQ-012 SHALL have port abort, input, 1 bit, terminates a sequence.
REQ-013 SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-014 SHALL have port starting_node, output, NODE_W bits, drives the path engine.
REQ-015 SHALL have port ending_node, output, NODE_W bits, drives the path engine.
REQ-016 SHALL have port direction_in, input, DIR_W bits, returned by the path engine.
REQ-017 SHALL have port leg_dir, output, DIR_W bits, captured direction word.
REQ-018 SHALL have port leg_valid, output, 1 bit, leg_dir is valid.
REQ-019 SHALL have port leg_ready, input, 1 bit, consumer accepts leg_dir.
REQ-020 SHALL have port leg_idx, output, 4 bits, index of the current leg.
REQ-021 SHALL have port seq_done, output, 1 bit, one-cycle pulse at sequence end.
REQ-022 SHALL have port err_short, output, 1 bit, one-cycle pulse when run is rejected.

Function
REQ-023 SHALL implement FSM states IDLE, SETTLE, PRESENT and DONE.
REQ-024 In IDLE, wp_wr SHALL store wp_data at index wp_count and increment wp_count; a write when wp_count==MAX_WP SHALL be ignored.
REQ-025 wp_clear SHALL set wp_count to 0 and has priority over a simultaneous wp_wr; both SHALL be ignored when busy.
REQ-026 When run is high in IDLE with wp_count>=2, the block SHALL load starting_node=wp[0], ending_node=wp[1], leg_idx=0 and counter=0, and SHALL enter SETTLE on the same edge.
REQ-027 When run is high in IDLE with wp_count<2, the block SHALL pulse err_short for one cycle and remain in IDLE.
REQ-028 run SHALL be ignored when not in IDLE.
REQ-029 In SETTLE, the counter SHALL increment every cycle with starting_node and ending_node held stable.
REQ-030 When the counter reaches SETTLE_CYCLES-1, the block SHALL register direction_in into leg_dir, set leg_valid, and enter PRESENT; capture SHALL occur exactly SETTLE_CYCLES cycles after the nodes change.
REQ-031 In PRESENT, leg_valid and leg_dir SHALL be held until leg_valid&&leg_ready is sampled high.
REQ-032 On handshake, if leg_idx+2 < wp_count, the block SHALL increment leg_idx, load starting_node=wp[leg_idx+1] and ending_node=wp[leg_idx+2], clear the counter, drop leg_valid and enter SETTLE.
REQ-033 On handshake for the final leg, the block SHALL drop leg_valid and enter DONE.
REQ-034 DONE SHALL assert seq_done for one cycle and return to IDLE; starting_node and ending_node SHALL keep the last leg's values.
REQ-035 abort in SETTLE or PRESENT SHALL drop leg_valid and return to IDLE on the next edge without a seq_done pulse, and SHALL take priority over a simultaneous handshake.
REQ-036 The waypoint table SHALL be retained across sequences and aborts, so a repeated run replays it.

Reset
REQ-037 While rst_n is low, the block SHALL force state=IDLE, wp_count=0, counter=0, leg_idx=0, starting_node=0, ending_node=0, leg_dir=0, and leg_valid, seq_done and err_short low; the table contents need not be cleared.
REQ-038 Reset asserted mid-sequence SHALL abandon the sequence immediately, asynchronously and without a seq_done pulse.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding and the NODE_W, DIR_W and MAX_WP defaults.
REQ-040 The waypoint table SHALL be one sub-module, waypoint_table (register array, synchronous write, combinational read, count logic); the path engine SHALL remain outside this block.

Verification (SETTLE_CYCLES=8)
REQ-041 Load 1,22,17 and run with leg_ready=1 -> legs (1,22) then (22,17); each leg_dir equals direction_in 8 cycles after the node change; seq_done pulses once; busy then falls.
REQ-042 Load a single waypoint 5 and run -> err_short pulses one cycle; busy stays 0.
REQ-043 Write 17 waypoints -> wp_count saturates at 16; the 17th value is never issued.
REQ-044 Hold leg_ready=0 for 50 cycles in PRESENT -> leg_valid and leg_dir stay stable and nodes do not advance.
REQ-045 Assert abort in SETTLE of leg 1, then run again -> sequence restarts at leg 0 (wp[0],wp[1]); no seq_done pulse from the aborted run.
REQ-046 Drop rst_n in PRESENT -> all outputs zero immediately; wp_count=0 after release.
